// File: rtl/lcd_cmd_if.sv
// Host/FSM-facing handshake bundle of the LCD command queue: write port and head-of-queue port.
interface lcd_cmd_if;
   logic       wr_valid;
   logic [9:0] wr_data;
   logic       wr_ready;
   logic       req_command;
   logic [9:0] buffer;
   logic       next_command;

   modport master (
      output wr_valid, wr_data, req_command,
      input  wr_ready, buffer, next_command
   );

   modport slave (
      input  wr_valid, wr_data, req_command,
      output wr_ready, buffer, next_command
   );
endinterface

// File: rtl/lcd_cmd_queue.sv
// Circular command queue feeding the LCD command FSM with {rw, rs, data[7:0]} words.
// Define LCD_INIT_SEQ_EN to preload the HD44780 4-bit initialisation sequence after reset.
module lcd_cmd_queue #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            flush,
   lcd_cmd_if.slave        cmd,
   output logic [ADDR_W:0] level,
   output logic            overflow,
   output logic            init_done
);

   localparam int unsigned LVL_W = ADDR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [9:0]        mem [DEPTH];
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              flush_run;
   logic              preload;
   logic [9:0]        preload_word;

`ifdef LCD_INIT_SEQ_EN
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t     state;
   logic [1:0] idx;

   // Initialisation ROM: function set, entry mode, display on, clear.
   always_comb begin
      preload_word = 10'h001;
      case (idx)
         2'd0:    preload_word = 10'h028;
         2'd1:    preload_word = 10'h006;
         2'd2:    preload_word = 10'h00C;
         default: preload_word = 10'h001;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_INIT;
         idx   <= 2'd0;
      end else if (state == ST_INIT) begin
         idx <= idx + 2'd1;
         if (idx == 2'd3) begin
            state <= ST_RUN;
         end
      end
   end

   assign preload   = (state == ST_INIT);
   assign init_done = (state == ST_RUN);
`else
   assign preload      = 1'b0;
   assign preload_word = 10'h000;
   assign init_done    = 1'b1;
`endif

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);

   // Handshake outputs depend only on registered state plus enable/flush gating;
   // reset also holds wr_ready low so the host cannot see a ready queue in reset.
   assign cmd.wr_ready     = reset && !full && init_done && !flush;
   assign cmd.next_command = enable && !empty && init_done;
   assign cmd.buffer       = empty ? 10'h000 : mem[rd_ptr];

   assign push      = cmd.wr_valid && cmd.wr_ready;
   assign pop       = cmd.req_command && enable && !empty && init_done;
   assign flush_run = flush && init_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (preload) begin
         wr_ptr <= wr_ptr + ADDR_W'(1);
         level  <= level + LVL_W'(1);
      end else if (flush_run) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (cmd.wr_valid && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; empty forces buffer to zero, so stale words never leak.
   always_ff @(posedge clk) begin
      if (preload) begin
         mem[wr_ptr] <= preload_word;
      end else if (push) begin
         mem[wr_ptr] <= cmd.wr_data;
      end
   end

endmodule
